// File: rtl/ct_secret_comparator_if.sv
// Handshake and data bundle for ct_secret_comparator.
// The master drives the request; the slave (the comparator) drives the status.
interface ct_secret_comparator_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 4,
  parameter int MAX_FAILS = 3
);
  localparam int FC_W = $clog2(MAX_FAILS + 1);

  logic                        start;
  logic [DATA_W*NUM_WORDS-1:0] secret_data;
  logic [DATA_W*NUM_WORDS-1:0] input_data;
  logic                        ready;
  logic                        done;
  logic                        match;
  logic                        locked;
  logic [FC_W-1:0]             fail_count;

  modport master (
    output start, secret_data, input_data,
    input  ready, done, match, locked, fail_count
  );

  modport slave (
    input  start, secret_data, input_data,
    output ready, done, match, locked, fail_count
  );
endinterface

// File: rtl/ct_secret_comparator.sv
// Constant-time multi-word secret comparator with start/done handshake and lockout
// after MAX_FAILS consecutive mismatches. Every word is visited on every compare.
module ct_secret_comparator #(
  parameter int DATA_W         = 8,
  parameter int NUM_WORDS      = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  ct_secret_comparator_if.slave  bus
);
  localparam int TOT_W = DATA_W * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, RESULT, LOCKOUT} state_t;

  state_t           state;
  logic [TOT_W-1:0] sec_q;
  logic [TOT_W-1:0] inp_q;
  logic             diff;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic             ready_q;
  logic             done_q;
  logic             match_q;
  logic             locked_q;
  logic [FC_W-1:0]  fc_q;

  logic             word_diff;
  logic [FC_W-1:0]  fc_next;

  always_comb begin
    word_diff = |(sec_q[idx*DATA_W +: DATA_W] ^ inp_q[idx*DATA_W +: DATA_W]);
    fc_next   = (fc_q == FC_W'(MAX_FAILS)) ? fc_q : fc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sec_q    <= '0;
      inp_q    <= '0;
      diff     <= 1'b0;
      idx      <= '0;
      timer    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
      locked_q <= 1'b0;
      fc_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sec_q   <= bus.secret_data;
            inp_q   <= bus.input_data;
            diff    <= 1'b0;
            idx     <= '0;
            ready_q <= 1'b0;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          diff <= diff | word_diff;
          idx  <= idx + 1'b1;
          // Result is registered on the last word so done and match appear together.
          if (idx == IDX_W'(NUM_WORDS - 1)) begin
            done_q  <= 1'b1;
            match_q <= ~(diff | word_diff);
            state   <= RESULT;
          end
        end
        RESULT: begin
          done_q  <= 1'b0;
          match_q <= 1'b0;
          sec_q   <= '0;
          inp_q   <= '0;
          idx     <= '0;
          if (!diff) begin
            fc_q    <= '0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            fc_q <= fc_next;
            if (fc_next == FC_W'(MAX_FAILS)) begin
              timer    <= TMR_W'(LOCKOUT_CYCLES);
              locked_q <= 1'b1;
              state    <= LOCKOUT;
            end else begin
              ready_q <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        LOCKOUT: begin
          timer <= timer - 1'b1;
          if (timer == TMR_W'(1)) begin
            fc_q     <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.match      = match_q;
  assign bus.locked     = locked_q;
  assign bus.fail_count = fc_q;
endmodule

// File: tb/tb_ct_secret_comparator.sv
// Directed bench for ct_secret_comparator: vector table for compare results and
// fail counting, plus hand sequences for lockout, held start and mid-compare reset.
module tb_ct_secret_comparator;
  localparam int DATA_W         = 8;
  localparam int NUM_WORDS      = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;
  // Edges after the accepting edge until done is visible.
  localparam int LAT = NUM_WORDS;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ct_secret_comparator_if #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .MAX_FAILS(MAX_FAILS)) bus ();

  ct_secret_comparator #(
    .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sec;
    logic [31:0] inp;
    logic        exp_m;
    int          exp_fc;
    logic        exp_lock;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the sample where done is seen (or on timeout).
  task automatic do_compare(input logic [31:0] sec, input logic [31:0] inp, input bit hold,
                            output logic m, output int lat, output bit stale);
    int w;
    w = 0;
    while (!bus.ready && w < 60) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_before_start", 32'(bus.ready), 32'd1);
    bus.secret_data = sec;
    bus.input_data  = inp;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    bus.input_data  = ~inp;
    bus.secret_data = 32'h0;
    m = 1'b0; lat = 0; stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        m = bus.match;
        break;
      end
      if (bus.match) stale = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  logic m;
  int   lat;
  bit   stale;
  int   cnt;
  int   dones;
  int   rdy_bad;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0, 1'b0};
    vecs[1] = '{32'hDEADBEEF, 32'hDEADBEEE, 1'b0, 1, 1'b0};
    vecs[2] = '{32'hDEADBEEF, 32'h00ADBEEF, 1'b0, 2, 1'b0};
    vecs[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0, 1'b0};
    vecs[4] = '{32'h12345678, 32'h12345678, 1'b1, 0, 1'b0};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 0, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 2, 1'b0};
    vecs[8] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 3, 1'b1};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.secret_data = '0;
    bus.input_data  = '0;
    #12;
    chk("rst_ready",  32'(bus.ready), 32'd1);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_match",  32'(bus.match), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_fc",     32'(bus.fail_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      do_compare(vecs[v].sec, vecs[v].inp, 1'b0, m, lat, stale);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(LAT));
      chk($sformatf("v%0d_match", v), 32'(m), 32'(vecs[v].exp_m));
      chk($sformatf("v%0d_stale_match", v), 32'(stale), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", v), 32'(bus.done), 32'd0);
      chk($sformatf("v%0d_match_after", v), 32'(bus.match), 32'd0);
      chk($sformatf("v%0d_fail_count", v), 32'(bus.fail_count), 32'(vecs[v].exp_fc));
      chk($sformatf("v%0d_locked", v), 32'(bus.locked), 32'(vecs[v].exp_lock));
      chk($sformatf("v%0d_ready", v), 32'(bus.ready), 32'(!vecs[v].exp_lock));
    end

    // Lockout window: starts held high throughout must be ignored.
    cnt = 0; dones = 0; rdy_bad = 0;
    bus.secret_data = 32'h11111111;
    bus.input_data  = 32'h11111111;
    while (bus.locked && cnt < 40) begin
      cnt++;
      bus.start = 1'b1;
      if (bus.ready) rdy_bad++;
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    chk("lock_cycles", 32'(cnt), 32'(LOCKOUT_CYCLES));
    chk("lock_no_done", 32'(dones), 32'd0);
    chk("lock_ready_low", 32'(rdy_bad), 32'd0);
    chk("lock_exit_ready", 32'(bus.ready), 32'd1);
    chk("lock_exit_fc", 32'(bus.fail_count), 32'd0);
    @(posedge clk); #1;
    chk("lock_start_dropped", 32'(bus.ready), 32'd1);

    // start held high through the compare, input changed after acceptance.
    do_compare(32'hCAFEBABE, 32'hCAFEBABE, 1'b1, m, lat, stale);
    chk("hold_latency", 32'(lat), 32'(LAT));
    chk("hold_match", 32'(m), 32'd1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("hold_single_done", 32'(dones), 32'd0);

    // Mid-compare reset, with a nonzero fail count beforehand.
    do_compare(32'h01020304, 32'h01020305, 1'b0, m, lat, stale);
    @(posedge clk); #1;
    chk("pre_reset_fc", 32'(bus.fail_count), 32'd1);
    bus.secret_data = 32'h55AA55AA;
    bus.input_data  = 32'h55AA55AA;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(bus.ready), 32'd1);
    chk("mid_rst_done",   32'(bus.done), 32'd0);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    chk("mid_rst_fc",     32'(bus.fail_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("mid_rst_no_done", 32'(dones), 32'd0);
    do_compare(32'h55AA55AA, 32'h55AA55AA, 1'b0, m, lat, stale);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_match", 32'(m), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
